// File: rtl/lc3b_control.sv
// Moore control FSM for the LC-3b multicycle datapath (ADD/AND/NOT/BR/LDR/STR).
// Controls are registered from the next state so they change cleanly on the clock edge.
module lc3b_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           opcode,
    input  logic                 branch_enable,
    input  logic                 mem_resp,
    output logic                 load_pc,
    output logic                 load_ir,
    output logic                 load_regfile,
    output logic                 load_mar,
    output logic                 load_mdr,
    output logic                 load_cc,
    output logic                 pcmux_sel,
    output logic                 storemux_sel,
    output logic                 alumux_sel,
    output logic                 regfilemux_sel,
    output logic                 marmux_sel,
    output logic                 mdrmux_sel,
    output logic [2:0]           aluop,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [1:0]           mem_byte_enable,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_AND  = 3'd1;
    localparam logic [2:0] ALU_NOT  = 3'd2;
    localparam logic [2:0] ALU_PASS = 3'd3;

    // Bit positions inside the packed control word.
    localparam int B_LD_PC  = 18;
    localparam int B_LD_IR  = 17;
    localparam int B_LD_RF  = 16;
    localparam int B_LD_MAR = 15;
    localparam int B_LD_MDR = 14;
    localparam int B_LD_CC  = 13;
    localparam int B_PCMUX  = 12;
    localparam int B_STMUX  = 11;
    localparam int B_ALUMUX = 10;
    localparam int B_RFMUX  = 9;
    localparam int B_MARMUX = 8;
    localparam int B_MDRMUX = 7;
    localparam int B_MEM_RD = 3;
    localparam int B_MEM_WR = 2;

    typedef enum logic [3:0] {
        S_RESET, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
        S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [18:0]            r_ctrl;
    logic [CNT_WIDTH-1:0]   r_count;

    function automatic logic [18:0] ctrl_of(input state_t st);
        logic [18:0] c;
        c = {12'b0, ALU_ADD, 1'b0, 1'b0, 2'b11};
        case (st)
            S_FETCH1: begin
                c[B_LD_MAR] = 1'b1;
                c[B_LD_PC]  = 1'b1;
            end
            S_FETCH2, S_LDR1: begin
                c[B_LD_MDR] = 1'b1;
                c[B_MEM_RD] = 1'b1;
            end
            S_FETCH3:   c[B_LD_IR] = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                c[B_LD_RF] = 1'b1;
                c[B_LD_CC] = 1'b1;
                c[6:4]     = (st == S_AND) ? ALU_AND : ((st == S_NOT) ? ALU_NOT : ALU_ADD);
            end
            S_BR_TAKEN: begin
                c[B_PCMUX] = 1'b1;
                c[B_LD_PC] = 1'b1;
            end
            S_CALC_ADDR: begin
                c[B_ALUMUX] = 1'b1;
                c[B_MARMUX] = 1'b1;
                c[B_LD_MAR] = 1'b1;
            end
            S_LDR2: begin
                c[B_RFMUX] = 1'b1;
                c[B_LD_RF] = 1'b1;
                c[B_LD_CC] = 1'b1;
            end
            S_STR1: begin
                c[B_STMUX]  = 1'b1;
                c[B_MDRMUX] = 1'b1;
                c[B_LD_MDR] = 1'b1;
                c[6:4]      = ALU_PASS;
            end
            S_STR2:     c[B_MEM_WR] = 1'b1;
            default:    c = {12'b0, ALU_ADD, 1'b0, 1'b0, 2'b11};
        endcase
        return c;
    endfunction

    // Next-state selection; memory waits hold until mem_resp.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:     w_next = S_FETCH1;
            S_FETCH1:    w_next = S_FETCH2;
            S_FETCH2:    w_next = mem_resp ? S_FETCH3 : S_FETCH2;
            S_FETCH3:    w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'b0001: w_next = S_ADD;
                    4'b0101: w_next = S_AND;
                    4'b1001: w_next = S_NOT;
                    4'b0000: w_next = S_BR;
                    4'b0110: w_next = S_CALC_ADDR;
                    4'b0111: w_next = S_CALC_ADDR;
                    default: w_next = S_FETCH1;
                endcase
            end
            S_BR:        w_next = branch_enable ? S_BR_TAKEN : S_FETCH1;
            S_CALC_ADDR: w_next = (opcode == 4'b0111) ? S_STR1 : S_LDR1;
            S_LDR1:      w_next = mem_resp ? S_LDR2 : S_LDR1;
            S_STR1:      w_next = S_STR2;
            S_STR2:      w_next = mem_resp ? S_FETCH1 : S_STR2;
            default:     w_next = S_FETCH1;
        endcase
    end

    // State, registered controls and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RESET;
            r_ctrl  <= ctrl_of(S_RESET);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next);
            if (w_next == S_FETCH1 && r_state != S_RESET) begin
                r_count <= r_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
        end
    end

    assign load_pc         = r_ctrl[B_LD_PC];
    assign load_ir         = r_ctrl[B_LD_IR];
    assign load_regfile    = r_ctrl[B_LD_RF];
    assign load_mar        = r_ctrl[B_LD_MAR];
    assign load_mdr        = r_ctrl[B_LD_MDR];
    assign load_cc         = r_ctrl[B_LD_CC];
    assign pcmux_sel       = r_ctrl[B_PCMUX];
    assign storemux_sel    = r_ctrl[B_STMUX];
    assign alumux_sel      = r_ctrl[B_ALUMUX];
    assign regfilemux_sel  = r_ctrl[B_RFMUX];
    assign marmux_sel      = r_ctrl[B_MARMUX];
    assign mdrmux_sel      = r_ctrl[B_MDRMUX];
    assign aluop           = r_ctrl[6:4];
    assign mem_read        = r_ctrl[B_MEM_RD];
    assign mem_write       = r_ctrl[B_MEM_WR];
    assign mem_byte_enable = r_ctrl[1:0];
    assign instr_count     = r_count;

endmodule

// File: tb/tb_lc3b_control.sv
// Randomized bench: each instruction is expanded into its expected per-cycle control rows,
// and a single negedge process compares the DUT against the current row.
module tb_lc3b_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    opcode;
    logic          branch_enable;
    logic          mem_resp;
    logic          load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc;
    logic          pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel;
    logic [2:0]    aluop;
    logic          mem_read, mem_write;
    logic [1:0]    mem_byte_enable;
    logic [CW-1:0] instr_count;

    lc3b_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_enable(branch_enable),
        .mem_resp(mem_resp), .load_pc(load_pc), .load_ir(load_ir),
        .load_regfile(load_regfile), .load_mar(load_mar), .load_mdr(load_mdr),
        .load_cc(load_cc), .pcmux_sel(pcmux_sel), .storemux_sel(storemux_sel),
        .alumux_sel(alumux_sel), .regfilemux_sel(regfilemux_sel),
        .marmux_sel(marmux_sel), .mdrmux_sel(mdrmux_sel), .aluop(aluop),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] c;
        bit          resp;
        bit          need_op;
        bit          br_row;
    } row_t;

    row_t          rows[$];
    int            checks = 0;
    int            errors = 0;
    bit            chk_en = 1'b0;
    logic [18:0]   exp_ctrl;
    logic [CW-1:0] exp_cnt;
    logic [CW-1:0] model_cnt = '0;

    localparam logic [18:0] IDLE = 19'h00003;

    // Field order: loads pc,ir,rf,mar,mdr,cc | muxes pc,store,alu,rf,mar,mdr | aluop | rd,wr | be
    function automatic logic [18:0] mk(input bit lpc, lir, lrf, lmar, lmdr, lcc,
                                        input bit pcm, stm, alm, rfm, mam, mdm,
                                        input logic [2:0] aop, input bit rd, wr);
        return {lpc, lir, lrf, lmar, lmdr, lcc, pcm, stm, alm, rfm, mam, mdm, aop, rd, wr, 2'b11};
    endfunction

    function automatic logic [18:0] actual();
        return {load_pc, load_ir, load_regfile, load_mar, load_mdr, load_cc,
                pcmux_sel, storemux_sel, alumux_sel, regfilemux_sel, marmux_sel, mdrmux_sel,
                aluop, mem_read, mem_write, mem_byte_enable};
    endfunction

    task automatic push(input logic [18:0] c, input bit is_wait, input bit last,
                        input bit need_op, input bit br);
        row_t r;
        r.c       = c;
        r.resp    = is_wait ? last : 1'($urandom_range(1, 0));
        r.need_op = need_op;
        r.br_row  = br;
        rows.push_back(r);
    endtask

    // Expand one instruction into the control rows it must produce, cycle by cycle.
    task automatic build(input logic [3:0] op, input bit be, input int lf, input int ld);
        rows.delete();
        push(mk(1,0,0,1,0,0, 0,0,0,0,0,0, 3'd0, 0,0), 0, 0, 0, 0);
        for (int i = 0; i < lf; i++) push(mk(0,0,0,0,1,0, 0,0,0,0,0,0, 3'd0, 1,0), 1, i == lf-1, 0, 0);
        push(mk(0,1,0,0,0,0, 0,0,0,0,0,0, 3'd0, 0,0), 0, 0, 0, 0);
        push(IDLE, 0, 0, 1, 0);
        case (op)
            4'b0001: push(mk(0,0,1,0,0,1, 0,0,0,0,0,0, 3'd0, 0,0), 0, 0, 0, 0);
            4'b0101: push(mk(0,0,1,0,0,1, 0,0,0,0,0,0, 3'd1, 0,0), 0, 0, 0, 0);
            4'b1001: push(mk(0,0,1,0,0,1, 0,0,0,0,0,0, 3'd2, 0,0), 0, 0, 0, 0);
            4'b0000: begin
                push(IDLE, 0, 0, 0, 1);
                if (be) push(mk(1,0,0,0,0,0, 1,0,0,0,0,0, 3'd0, 0,0), 0, 0, 0, 0);
            end
            4'b0110, 4'b0111: begin
                push(mk(0,0,0,1,0,0, 0,0,1,0,1,0, 3'd0, 0,0), 0, 0, 1, 0);
                if (op == 4'b0110) begin
                    for (int i = 0; i < ld; i++) push(mk(0,0,0,0,1,0, 0,0,0,0,0,0, 3'd0, 1,0), 1, i == ld-1, 0, 0);
                    push(mk(0,0,1,0,0,1, 0,0,0,1,0,0, 3'd0, 0,0), 0, 0, 0, 0);
                end else begin
                    push(mk(0,0,0,0,1,0, 0,1,0,0,0,1, 3'd3, 0,0), 0, 0, 0, 0);
                    for (int i = 0; i < ld; i++) push(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 3'd0, 0,1), 1, i == ld-1, 0, 0);
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // The single per-cycle comparator.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl", 32'(actual()), 32'(exp_ctrl));
            check("instr_count", 32'(instr_count), 32'(exp_cnt));
        end
    end

    task automatic hold_reset();
        exp_ctrl  = IDLE;
        exp_cnt   = '0;
        model_cnt = '0;
        mem_resp  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #0;
        rst_n = 1'b1;
    endtask

    // Run one instruction; abort_at >= 0 asserts reset mid-cycle at that row.
    task automatic run_instr(input logic [3:0] op, input bit be, input int lf, input int ld,
                             input int abort_at);
        build(op, be, lf, ld);
        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk);
            #1;
            exp_ctrl      = rows[i].c;
            exp_cnt       = model_cnt;
            mem_resp      = rows[i].resp;
            branch_enable = rows[i].br_row ? be : 1'($urandom_range(1, 0));
            opcode        = rows[i].need_op ? op : 4'($urandom_range(15, 0));
            if (i == abort_at) begin
                #2;
                rst_n    = 1'b0;
                exp_ctrl = IDLE;
                exp_cnt  = '0;
                #1;
                check("mem_write_async_drop", 32'(mem_write), 32'd0);
                check("mem_read_async_drop", 32'(mem_read), 32'd0);
                check("count_async_clear", 32'(instr_count), 32'd0);
                hold_reset();
                return;
            end
        end
        model_cnt = model_cnt + 1'b1;
    endtask

    task automatic len_check(input string name, input logic [3:0] op, input bit be,
                             input int lf, input int ld, input int want);
        build(op, be, lf, ld);
        check(name, 32'(rows.size()), 32'(want));
    endtask

    initial begin
        rst_n         = 1'b0;
        mem_resp      = 1'b1;
        opcode        = 4'b0000;
        branch_enable = 1'b0;
        exp_ctrl      = IDLE;
        exp_cnt       = '0;

        len_check("len_alu",     4'b0001, 0, 1, 1, 5);
        len_check("len_br_nt",   4'b0000, 0, 1, 1, 5);
        len_check("len_br_t",    4'b0000, 1, 1, 1, 6);
        len_check("len_ldr",     4'b0110, 0, 1, 1, 7);
        len_check("len_str",     4'b0111, 0, 1, 1, 7);
        len_check("len_ldr_3_3", 4'b0110, 0, 3, 3, 11);

        chk_en = 1'b1;
        @(posedge clk);
        hold_reset();

        run_instr(4'b0001, 0, 1, 1, -1);
        check("count_after_add", 32'(model_cnt), 32'd1);
        run_instr(4'b0000, 1, 1, 1, -1);
        run_instr(4'b0000, 0, 1, 1, -1);
        run_instr(4'b0110, 0, 3, 3, -1);
        run_instr(4'b0111, 0, 1, 2, -1);
        run_instr(4'b1111, 0, 1, 1, -1);
        run_instr(4'b0111, 0, 2, 3, 7);

        for (int n = 0; n < 80; n++) begin
            logic [3:0] op;
            case ($urandom_range(7, 0))
                0: op = 4'b0001;
                1: op = 4'b0101;
                2: op = 4'b1001;
                3: op = 4'b0000;
                4: op = 4'b0110;
                5: op = 4'b0111;
                default: op = 4'($urandom_range(15, 0));
            endcase
            run_instr(op, 1'($urandom_range(1, 0)), $urandom_range(4, 1), $urandom_range(4, 1),
                      (n == 40) ? 2 : -1);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
